// File: rtl/button_scheduler_if.sv
//------------------------------------------------------------------------------
// button_scheduler_if
//   Command handshake between the button scheduler and the downstream
//   configuration FSM (valid/ready, one command per transfer).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface button_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_id;
    logic       cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_id,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface

`default_nettype wire

// File: rtl/button_scheduler.sv
//------------------------------------------------------------------------------
// button_scheduler
//   Shared-timebase debounce for four buttons, press/auto-repeat event
//   generation and round-robin command arbitration onto a valid/ready link.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_scheduler #(
    parameter int DB_BITS      = 22,
    parameter int REPEAT_TICKS = 12
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [3:0]         btn_raw,
    output logic      [3:0]         btn_level,
    button_scheduler_if.master      cmd
);

    localparam logic [3:0] c_REP_LAST = 4'(REPEAT_TICKS - 1);
    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_OFFER  = 1'b1;

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [DB_BITS-1:0] r_timer;
    logic [3:0]         r_prev;
    logic [3:0]         r_level;
    logic [3:0]         r_level_q;
    logic [3:0][3:0]    r_hold;
    logic [3:0]         r_pending;
    logic [3:0]         r_rep_flag;

    logic               w_tick;
    logic [3:0]         w_level_next;
    logic [3:0]         w_rise;
    logic [3:0]         w_fall;
    logic [3:0]         w_rep_evt;
    logic [3:0][3:0]    w_hold_next;
    logic [3:0]         w_pending_next;
    logic [3:0]         w_rep_flag_next;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               r_valid;
    logic               w_valid_next;
    logic [1:0]         r_id;
    logic [1:0]         w_id_next;
    logic               r_rep;
    logic               w_rep_next;
    logic [1:0]         r_last;
    logic [1:0]         w_last_next;
    logic               w_hs;
    logic [1:0]         w_sel;
    logic [1:0]         w_cand;
    logic               w_found;

    assign w_tick = &r_timer;

    // A level only moves when this tick's sample agrees with the previous one.
    assign w_level_next = w_tick ? ((r_sync2 & r_prev) | (r_level & (r_sync2 | r_prev)))
                                 : r_level;
    assign w_rise = r_level & ~r_level_q;
    assign w_fall = ~r_level & r_level_q;

    always_comb begin
        w_hold_next     = r_hold;
        w_pending_next  = r_pending;
        w_rep_flag_next = r_rep_flag;
        w_rep_evt       = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_rise[i] || w_fall[i]) begin
                w_hold_next[i] = '0;
            end else if (w_tick && r_level[i] && w_level_next[i]) begin
                if (r_hold[i] == c_REP_LAST) begin
                    w_hold_next[i] = '0;
                    w_rep_evt[i]   = 1'b1;
                end else begin
                    w_hold_next[i] = r_hold[i] + 4'd1;
                end
            end
            if (w_hs && (r_id == 2'(i))) begin
                w_pending_next[i] = 1'b0;
            end
            // A fresh press overrides a same-cycle handshake clear.
            if (w_rise[i]) begin
                w_pending_next[i]  = 1'b1;
                w_rep_flag_next[i] = 1'b0;
            end else if (w_rep_evt[i] && !r_pending[i]) begin
                w_pending_next[i]  = 1'b1;
                w_rep_flag_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_timer    <= '0;
            r_prev     <= '0;
            r_level    <= '0;
            r_level_q  <= '0;
            r_hold     <= '0;
            r_pending  <= '0;
            r_rep_flag <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_timer    <= r_timer + 1'b1;
            r_level_q  <= r_level;
            r_level    <= w_level_next;
            r_hold     <= w_hold_next;
            r_pending  <= w_pending_next;
            r_rep_flag <= w_rep_flag_next;
            if (w_tick) begin
                r_prev <= r_sync2;
            end
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        w_sel   = r_last + 2'd1;
        w_cand  = r_last + 2'd1;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_last + 2'(k + 1);
            if (!w_found && r_pending[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_id_next    = r_id;
        w_rep_next   = r_rep;
        w_last_next  = r_last;
        w_hs         = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_found) begin
                    w_state_next = c_S_OFFER;
                    w_valid_next = 1'b1;
                    w_id_next    = w_sel;
                    w_rep_next   = r_rep_flag[w_sel];
                end
            end
            default: begin
                if (cmd.cmd_ready) begin
                    w_hs         = 1'b1;
                    w_state_next = c_S_IDLE;
                    w_valid_next = 1'b0;
                    w_last_next  = r_id;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_valid <= 1'b0;
            r_id    <= 2'd0;
            r_rep   <= 1'b0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_id    <= w_id_next;
            r_rep   <= w_rep_next;
            r_last  <= w_last_next;
        end
    end

    assign cmd.cmd_valid  = r_valid;
    assign cmd.cmd_id     = r_id;
    assign cmd.cmd_repeat = r_rep;
    assign btn_level      = r_level;

endmodule

`default_nettype wire

// File: tb/tb_button_scheduler.sv
//------------------------------------------------------------------------------
// tb_button_scheduler
//   Directed bench for button_scheduler with a 16-cycle tick and 3-tick repeat.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;

    button_scheduler_if cmd_if ();

    button_scheduler #(
        .DB_BITS      (4),
        .REPEAT_TICKS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .cmd       (cmd_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int vcnt    = 0;
    int t_rel   = 0;
    int hs_id[$];
    int hs_rep[$];
    int hs_cyc[$];

    // Transfer log, sampled on the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && cmd_if.cmd_valid) begin
            vcnt <= vcnt + 1;
            if (cmd_if.cmd_ready) begin
                hs_id.push_back(int'(cmd_if.cmd_id));
                hs_rep.push_back(int'(cmd_if.cmd_repeat));
                hs_cyc.push_back(cyc);
            end
        end
    end

    // Position 0 is the negedge after the last reset-asserted posedge.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        reset            = 1'b1;
        btn_raw          = 4'b0000;
        cmd_if.cmd_ready = ready;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t_rel = 0;
    endtask

    task automatic step_to(input int n);
        while (t_rel < n) begin
            @(negedge clk);
            t_rel++;
        end
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        n_total++;
        if (cmd_if.cmd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", cmd_if.cmd_valid);
        else n_pass++;
        n_total++;
        if (cmd_if.cmd_id !== 2'd0) $display("FAIL reset_id got %0d want 0", cmd_if.cmd_id);
        else n_pass++;
        n_total++;
        if (cmd_if.cmd_repeat !== 1'b0) $display("FAIL reset_repeat got %b want 0", cmd_if.cmd_repeat);
        else n_pass++;
        n_total++;
        if (btn_level !== 4'b0000) $display("FAIL reset_level got %b want 0000", btn_level);
        else n_pass++;
    endtask

    task automatic test_clean_press;
        int n0, v0, gid, grep;
        do_reset(1'b1);
        n0 = hs_id.size();
        v0 = vcnt;
        btn_raw = 4'b0100;
        step_to(33);
        n_total++;
        if (cmd_if.cmd_valid !== 1'b0) $display("FAIL press_early_valid got %b want 0", cmd_if.cmd_valid);
        else n_pass++;
        step_to(40);
        gid  = (hs_id.size() > n0) ? hs_id[n0] : -1;
        grep = (hs_id.size() > n0) ? hs_rep[n0] : -1;
        n_total++;
        if (hs_id.size() - n0 !== 1) $display("FAIL press_count got %0d want 1", hs_id.size() - n0);
        else n_pass++;
        n_total++;
        if (gid !== 2) $display("FAIL press_id got %0d want 2", gid);
        else n_pass++;
        n_total++;
        if (grep !== 0) $display("FAIL press_repeat got %0d want 0", grep);
        else n_pass++;
        n_total++;
        if (vcnt - v0 !== 1) $display("FAIL press_valid_cycles got %0d want 1", vcnt - v0);
        else n_pass++;
        n_total++;
        if (btn_level !== 4'b0100) $display("FAIL press_level got %b want 0100", btn_level);
        else n_pass++;
    endtask

    task automatic test_bounce;
        int n0;
        logic seen;
        do_reset(1'b1);
        n0   = hs_id.size();
        seen = 1'b0;
        for (int t = 0; t <= 100; t++) begin
            step_to(t);
            if (t < 40 && (t % 5) == 0) btn_raw[0] = ((t / 5) % 2 == 0);
            else if (t == 40) btn_raw[0] = 1'b0;
            if (btn_level[0] !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL bounce_level got high want low");
        else n_pass++;
        n_total++;
        if (hs_id.size() - n0 !== 0) $display("FAIL bounce_cmds got %0d want 0", hs_id.size() - n0);
        else n_pass++;
    endtask

    task automatic test_auto_repeat;
        int n0;
        logic bad;
        do_reset(1'b1);
        n0 = hs_id.size();
        btn_raw = 4'b0010;
        step_to(192);
        btn_raw = 4'b0000;
        step_to(300);
        n_total++;
        if (hs_id.size() - n0 !== 4) $display("FAIL repeat_count got %0d want 4", hs_id.size() - n0);
        else n_pass++;
        if (hs_id.size() - n0 == 4) begin
            n_total++;
            if (hs_rep[n0] !== 0 || hs_id[n0] !== 1)
                $display("FAIL repeat_first got id=%0d rep=%0d want id=1 rep=0", hs_id[n0], hs_rep[n0]);
            else n_pass++;
            bad = 1'b0;
            for (int k = 1; k < 4; k++) if (hs_rep[n0+k] !== 1 || hs_id[n0+k] !== 1) bad = 1'b1;
            n_total++;
            if (bad) $display("FAIL repeat_flags got non-repeat entries want id=1 rep=1");
            else n_pass++;
            bad = 1'b0;
            for (int k = 2; k < 4; k++) if (hs_cyc[n0+k] - hs_cyc[n0+k-1] !== 48) bad = 1'b1;
            n_total++;
            if (bad) $display("FAIL repeat_spacing got %0d want 48", hs_cyc[n0+2] - hs_cyc[n0+1]);
            else n_pass++;
        end
        n_total++;
        if (btn_level !== 4'b0000) $display("FAIL repeat_release_level got %b want 0000", btn_level);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        int n0;
        logic bad;
        do_reset(1'b0);
        n0 = hs_id.size();
        btn_raw = 4'b1101;
        bad = 1'b0;
        for (int t = 36; t <= 50; t++) begin
            step_to(t);
            if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_id !== 2'd0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL rr_stall got valid=%b id=%0d want valid=1 id=0", cmd_if.cmd_valid, cmd_if.cmd_id);
        else n_pass++;
        cmd_if.cmd_ready = 1'b1;
        step_to(60);
        n_total++;
        if (hs_id.size() - n0 !== 3) $display("FAIL rr_count got %0d want 3", hs_id.size() - n0);
        else n_pass++;
        if (hs_id.size() - n0 == 3) begin
            n_total++;
            if (hs_id[n0] !== 0) $display("FAIL rr_grant0 got %0d want 0", hs_id[n0]);
            else n_pass++;
            n_total++;
            if (hs_id[n0+1] !== 2) $display("FAIL rr_grant1 got %0d want 2", hs_id[n0+1]);
            else n_pass++;
            n_total++;
            if (hs_id[n0+2] !== 3) $display("FAIL rr_grant2 got %0d want 3", hs_id[n0+2]);
            else n_pass++;
            n_total++;
            if (hs_cyc[n0+1] - hs_cyc[n0] !== 2 || hs_cyc[n0+2] - hs_cyc[n0+1] !== 2)
                $display("FAIL rr_back_to_back got %0d want 2", hs_cyc[n0+1] - hs_cyc[n0]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int n0;
        logic bad;
        do_reset(1'b0);
        n0 = hs_id.size();
        btn_raw = 4'b0010;
        bad = 1'b0;
        for (int t = 40; t <= 140; t++) begin
            step_to(t);
            if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_id !== 2'd1 || cmd_if.cmd_repeat !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad || hs_id.size() != n0)
            $display("FAIL bp_stable got valid=%b id=%0d rep=%b want 1/1/0", cmd_if.cmd_valid, cmd_if.cmd_id, cmd_if.cmd_repeat);
        else n_pass++;
        cmd_if.cmd_ready = 1'b1;
        step_to(150);
        n_total++;
        if (hs_id.size() - n0 !== 1) $display("FAIL bp_delivered got %0d want 1", hs_id.size() - n0);
        else n_pass++;
        n_total++;
        if (hs_id.size() <= n0 || hs_rep[n0] !== 0) $display("FAIL bp_repeat_flag got non-press want rep=0");
        else n_pass++;
    endtask

    task automatic test_reset_mid_offer;
        int n0, v0;
        do_reset(1'b0);
        btn_raw = 4'b1000;
        step_to(40);
        n_total++;
        if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_id !== 2'd3)
            $display("FAIL rst_offer got valid=%b id=%0d want 1/3", cmd_if.cmd_valid, cmd_if.cmd_id);
        else n_pass++;
        reset   = 1'b1;
        btn_raw = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if (cmd_if.cmd_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", cmd_if.cmd_valid);
        else n_pass++;
        n_total++;
        if (btn_level !== 4'b0000) $display("FAIL rst_level got %b want 0000", btn_level);
        else n_pass++;
        n_total++;
        if (cmd_if.cmd_id !== 2'd0) $display("FAIL rst_id got %0d want 0", cmd_if.cmd_id);
        else n_pass++;
        cmd_if.cmd_ready = 1'b1;
        n0 = hs_id.size();
        v0 = vcnt;
        repeat (100) @(negedge clk);
        n_total++;
        if (hs_id.size() - n0 !== 0 || vcnt - v0 !== 0)
            $display("FAIL rst_reissue got %0d cmds want 0", hs_id.size() - n0);
        else n_pass++;
    endtask

    initial begin
        reset            = 1'b1;
        btn_raw          = 4'b0000;
        cmd_if.cmd_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_round_robin();
        test_backpressure();
        test_reset_mid_offer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
